// File: rtl/chacha_block_sched_if.sv
// Handshake bundle between the state loader, the ChaCha block sequencer
// and the keystream XOR stage.
interface chacha_block_sched_if;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_state;
   logic         out_valid;
   logic         out_ready;
   logic [511:0] out_block;

   modport master (
      output in_valid, in_state, out_ready,
      input  in_ready, out_valid, out_block
   );

   modport slave (
      input  in_valid, in_state, out_ready,
      output in_ready, out_valid, out_block
   );
endinterface

// File: rtl/chacha_block_sched.sv
// ChaCha block function: one shared quarter-round per cycle over a
// 16-word working state, followed by the feed-forward add.
module quarter_cha (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic [31:0] c_i,
   input  logic [31:0] d_i,
   output logic [31:0] a_o,
   output logic [31:0] b_o,
   output logic [31:0] c_o,
   output logic [31:0] d_o
);
   logic [31:0] a1, d1x, d1, c1, b1x, b1;
   logic [31:0] d2x, b2x;

   assign a1  = a_i + b_i;
   assign d1x = d_i ^ a1;
   assign d1  = {d1x[15:0], d1x[31:16]};
   assign c1  = c_i + d1;
   assign b1x = b_i ^ c1;
   assign b1  = {b1x[19:0], b1x[31:20]};
   assign a_o = a1 + b1;
   assign d2x = d1 ^ a_o;
   assign d_o = {d2x[23:0], d2x[31:24]};
   assign c_o = c1 + d_o;
   assign b2x = b1 ^ c_o;
   assign b_o = {b2x[24:0], b2x[31:25]};
endmodule

module chacha_block_sched #(
   parameter int ROUNDS = 20
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 abort,
   output logic                 busy,
   chacha_block_sched_if.slave  bus
);
   typedef enum logic [1:0] {IDLE, ROUND, FEED, DONE} state_e;

   localparam logic [7:0] LAST = 8'(ROUNDS - 2);

   state_e            state_q, state_d;
   logic [15:0][31:0] work_q, work_d;
   logic [15:0][31:0] init_q, init_d;
   logic [15:0][31:0] blk_q, blk_d;
   logic [2:0]        qr_q, qr_d;
   logic [7:0]        rnd_q, rnd_d;

   logic [1:0]  j;
   logic        dg;
   logic [3:0]  ia, ib, ic, id;
   logic [31:0] qa, qb, qc, qd;

   // Diagonal pass rotates rows 1..3 left by 1..3 columns.
   assign j  = qr_q[1:0];
   assign dg = qr_q[2];
   assign ia = {2'b00, j};
   assign ib = {2'b01, j + {1'b0, dg}};
   assign ic = {2'b10, j + {dg, 1'b0}};
   assign id = {2'b11, j + {dg, dg}};

   quarter_cha u_qr (
      .a_i (work_q[ia]),
      .b_i (work_q[ib]),
      .c_i (work_q[ic]),
      .d_i (work_q[id]),
      .a_o (qa),
      .b_o (qb),
      .c_o (qc),
      .d_o (qd)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (abort) begin
         state_d = IDLE;
      end else begin
         unique case (state_q)
            IDLE:  if (bus.in_valid) state_d = ROUND;
            ROUND: if (qr_q == 3'd7 && rnd_q == LAST) state_d = FEED;
            FEED:  state_d = DONE;
            DONE:  if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   always_comb begin
      bus.in_ready  = rst_n && (state_q == IDLE);
      bus.out_valid = (state_q == DONE);
      busy          = (state_q == ROUND) || (state_q == FEED);
   end

   always_comb begin
      work_d = work_q;
      init_d = init_q;
      blk_d  = blk_q;
      qr_d   = qr_q;
      rnd_d  = rnd_q;
      if (abort) begin
         qr_d  = '0;
         rnd_d = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (bus.in_valid) begin
                  init_d = bus.in_state;
                  work_d = bus.in_state;
                  qr_d   = '0;
                  rnd_d  = '0;
               end
            end
            ROUND: begin
               work_d[ia] = qa;
               work_d[ib] = qb;
               work_d[ic] = qc;
               work_d[id] = qd;
               qr_d       = qr_q + 3'd1;
               if (qr_q == 3'd7) rnd_d = rnd_q + 8'd2;
            end
            FEED: begin
               for (int i = 0; i < 16; i++)
                  blk_d[i] = work_q[i] + init_q[i];
               rnd_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         work_q <= '0;
         init_q <= '0;
         blk_q  <= '0;
         qr_q   <= '0;
         rnd_q  <= '0;
      end else begin
         work_q <= work_d;
         init_q <= init_d;
         blk_q  <= blk_d;
         qr_q   <= qr_d;
         rnd_q  <= rnd_d;
      end
   end

   assign bus.out_block = blk_q;
endmodule
